// File: rtl/seg7_decoder.sv
// Seven-segment pattern decoder with a strobe-qualified stability filter,
// duplicate suppression, and a one-entry result register with drop flag.
//
// Result register FSM:
//   state | meaning
//   EMPTY | no unconsumed result, out_valid=0
//   FULL  | result held in bcd/blank/err, out_valid=1
module seg7_decoder #(
    parameter int STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       seg_stb,
    output logic [3:0] bcd_out,
    output logic       blank_out,
    output logic       err_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam logic [3:0] STC = 4'(STABLE_CNT);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t     state, state_nxt;
    logic [6:0] cand;
    logic [6:0] last_pat;
    logic [3:0] cnt;
    logic       reported;
    logic       match, qualify, result;
    logic       load, drop;
    logic [3:0] dec_bcd;
    logic       dec_blank, dec_err;

    // Qualifying event: this strobe brings the run length to exactly STC;
    // a result is generated only if the pattern differs from the last report.
    always_comb begin
        match   = (seg_in == cand);
        qualify = 1'b0;
        if (seg_stb) begin
            if (match)
                qualify = (cnt != STC) && ((cnt + 4'd1) == STC);
            else
                qualify = (STC == 4'd1);
        end
        result = qualify && (!reported || (seg_in != last_pat));
    end

    // Result register next state; drop when a result arrives while held.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (result) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (result)
                        load = 1'b1;
                    else
                        state_nxt = EMPTY;
                end else if (result) begin
                    drop = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Pattern to digit decode; anything unlisted is an error except all-off.
    always_comb begin
        dec_bcd   = 4'hF;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_in)
            7'b1111110: dec_bcd = 4'd0;
            7'b0110000: dec_bcd = 4'd1;
            7'b1101101: dec_bcd = 4'd2;
            7'b1111001: dec_bcd = 4'd3;
            7'b0110011: dec_bcd = 4'd4;
            7'b1011011: dec_bcd = 4'd5;
            7'b0011111: dec_bcd = 4'd6;
            7'b1110000: dec_bcd = 4'd7;
            7'b1111111: dec_bcd = 4'd8;
            7'b1110011: dec_bcd = 4'd9;
            7'b0000000: dec_blank = 1'b1;
            default:    dec_err   = 1'b1;
        endcase
    end

    // Stability filter and duplicate-suppression state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand     <= 7'd0;
            cnt      <= 4'd0;
            last_pat <= 7'd0;
            reported <= 1'b0;
        end else begin
            if (seg_stb) begin
                if (!match) begin
                    cand <= seg_in;
                    cnt  <= 4'd1;
                end else if (cnt != STC) begin
                    cnt <= cnt + 4'd1;
                end
            end
            if (result) begin
                last_pat <= seg_in;
                reported <= 1'b1;
            end
        end
    end

    // Result register, FSM state and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            bcd_out   <= 4'd0;
            blank_out <= 1'b0;
            err_out   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                bcd_out   <= dec_bcd;
                blank_out <= dec_blank;
                err_out   <= dec_err;
            end
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder: decode table vectors, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_seg7_decoder;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'd0;
    logic       seg_stb = 1'b0;
    logic       out_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] bcd_out;
    logic       blank_out, err_out, out_valid, ovf;

    int errors = 0;
    int checks = 0;

    seg7_decoder #(.STABLE_CNT(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .seg_stb(seg_stb),
        .bcd_out(bcd_out), .blank_out(blank_out), .err_out(err_out),
        .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [6:0] digit_pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101,
                                   7'b1111001, 7'b0110011, 7'b1011011,
                                   7'b0011111, 7'b1110000, 7'b1111111,
                                   7'b1110011};
    logic [6:0] hist [$];
    logic       m_rep, m_valid, m_blank, m_err, m_ovf;
    logic [6:0] m_last;
    logic [3:0] m_bcd;

    task automatic model_reset();
        hist.delete();
        m_rep = 0; m_last = 0; m_valid = 0; m_bcd = 0;
        m_blank = 0; m_err = 0; m_ovf = 0;
    endtask

    task automatic model_decode(input logic [6:0] p, output logic [3:0] b,
                                output logic bl, output logic er);
        b = 4'hF; bl = (p == 7'd0); er = (p != 7'd0);
        for (int i = 0; i < 10; i++)
            if (digit_pat[i] == p) begin b = 4'(i); er = 0; end
    endtask

    // Trailing run length of identical strobed samples since reset.
    function automatic int run_len();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_step(input logic r, input logic [6:0] p,
                              input logic st, input logic rdy,
                              input logic clr);
        logic res, drop;
        logic [3:0] b; logic bl, er;
        if (!r) begin model_reset(); return; end
        res = 0; drop = 0;
        if (st) begin
            hist.push_back(p);
            if (hist.size() > S + 2) void'(hist.pop_front());
            res = (run_len() == S) && (!m_rep || p != m_last);
        end
        if (res) begin
            m_rep = 1; m_last = p;
            if (!m_valid || rdy) begin
                model_decode(p, b, bl, er);
                m_bcd = b; m_blank = bl; m_err = er; m_valid = 1;
            end else begin
                drop = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; model updated, outputs compared #1 later.
    task automatic step(input logic r, input logic [6:0] p, input logic st,
                        input logic rdy, input logic clr);
        rst_n = r; seg_in = p; seg_stb = st; out_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        model_step(r, p, st, rdy, clr);
        #1;
        check("model", {28'd0, out_valid, ovf, blank_out, err_out, bcd_out} >> 0,
              {28'd0, m_valid, m_ovf, m_blank, m_err, m_bcd});
    endtask

    task automatic do_reset();
        step(0, 7'd0, 0, 0, 0);
        step(1, 7'd0, 0, 0, 0);
    endtask

    typedef struct {
        logic [6:0] seg;
        logic [3:0] bcd;
        logic       blank;
        logic       err;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{7'b0000000, 4'hF, 1, 0};
        vecs[1]  = '{7'b1111110, 4'd0, 0, 0};
        vecs[2]  = '{7'b0110000, 4'd1, 0, 0};
        vecs[3]  = '{7'b1101101, 4'd2, 0, 0};
        vecs[4]  = '{7'b1111001, 4'd3, 0, 0};
        vecs[5]  = '{7'b0110011, 4'd4, 0, 0};
        vecs[6]  = '{7'b1011011, 4'd5, 0, 0};
        vecs[7]  = '{7'b0011111, 4'd6, 0, 0};
        vecs[8]  = '{7'b1110000, 4'd7, 0, 0};
        vecs[9]  = '{7'b1111111, 4'd8, 0, 0};
        vecs[10] = '{7'b1110011, 4'd9, 0, 0};
        vecs[11] = '{7'b1000000, 4'hF, 0, 1};
        vecs[12] = '{7'b1111100, 4'hF, 0, 1};

        model_reset();
        step(0, 7'd0, 0, 0, 0);
        check("reset_state", {out_valid, ovf, blank_out, err_out, bcd_out}, 8'h00);
        step(1, 7'd0, 0, 0, 0);

        // Decode table, each pattern held for S strobes then consumed.
        foreach (vecs[i]) begin
            for (int k = 0; k < S; k++) begin
                if (k == S - 1)
                    check("pre_valid", out_valid, 0);
                step(1, vecs[i].seg, 1, 0, 0);
            end
            check("vec_valid", out_valid, 1);
            check("vec_dec", {bcd_out, blank_out, err_out},
                  {vecs[i].bcd, vecs[i].blank, vecs[i].err});
            step(1, vecs[i].seg, 0, 1, 0);
            check("vec_consumed", out_valid, 0);
        end

        // Digit 2 held, fourth strobe gives nothing new.
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 7'b1101101, 1, 1, 0);
        check("d2_valid", {out_valid, bcd_out, err_out}, {1'b1, 4'd2, 1'b0});
        step(1, 7'b1101101, 1, 1, 0);
        check("d2_no_repeat", out_valid, 0);

        // Interrupted run of 3 only qualifies on the sixth strobe.
        do_reset();
        begin
            logic [6:0] seq [6] = '{7'b1111001, 7'b1111001, 7'b0110000,
                                    7'b1111001, 7'b1111001, 7'b1111001};
            for (int k = 0; k < 6; k++) begin
                check("d3_early", out_valid, 0);
                step(1, seq[k], 1, 1, 0);
            end
            check("d3_result", {out_valid, bcd_out}, {1'b1, 4'd3});
            step(1, 7'd0, 0, 1, 0);
        end

        // Drop while full, then consume and clear overflow.
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 7'b1011011, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 7'b1110000, 1, 0, 0);
        check("ovf_hold", {out_valid, bcd_out, ovf}, {1'b1, 4'd5, 1'b1});
        step(1, 7'd0, 0, 1, 0);
        check("ovf_consumed", {out_valid, ovf}, 2'b01);
        step(1, 7'd0, 0, 0, 1);
        check("ovf_cleared", ovf, 0);

        // Accept and load in the same cycle.
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 7'b0110011, 1, 0, 0);
        step(1, 7'b1110011, 1, 0, 0);
        step(1, 7'b1110011, 1, 0, 0);
        check("hold4", {out_valid, bcd_out}, {1'b1, 4'd4});
        step(1, 7'b1110011, 1, 1, 0);
        check("swap9", {out_valid, bcd_out, ovf}, {1'b1, 4'd9, 1'b0});

        // Drop coinciding with clear leaves ovf set.
        step(1, 7'b1111111, 1, 0, 0);
        step(1, 7'b1111111, 1, 0, 0);
        step(1, 7'b1111111, 1, 0, 1);
        check("ovf_set_wins", {ovf, bcd_out}, {1'b1, 4'd9});

        // Reset mid-count restarts the filter.
        do_reset();
        step(1, 7'b0110011, 1, 1, 0);
        step(1, 7'b0110011, 1, 1, 0);
        step(0, 7'b0110011, 0, 1, 0);
        step(1, 7'b0110011, 1, 1, 0);
        check("rst_restart", out_valid, 0);
        step(1, 7'b0110011, 1, 0, 0);
        check("rst_restart2", out_valid, 0);
        step(1, 7'b0110011, 1, 0, 0);
        check("rst_result", {out_valid, bcd_out}, {1'b1, 4'd4});

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] p;
            case ($urandom_range(0, 4))
                0: p = 7'b1101101;
                1: p = 7'b1110000;
                2: p = 7'd0;
                3: p = digit_pat[$urandom_range(0, 9)];
                default: p = 7'($urandom);
            endcase
            step(($urandom_range(0, 199) != 0), p,
                 ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 Parameter STABLE_CNT, default 3, number of consecutive identical strobed samples before a pattern counts as stable; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 seg_in  input  7  segment pattern, active-high, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-005 seg_stb  input  1  sample strobe; seg_in is sampled only in cycles where seg_stb=1.
REQ-006 bcd_out  output  4  decoded digit.
REQ-007 blank_out  output  1  reported pattern was all-off.
REQ-008 err_out  output  1  reported pattern was not a legal digit or blank.
REQ-009 out_valid  output  1  result register holds an unconsumed result.
REQ-010 out_ready  input  1  consumer accepts the result when out_valid=1 and out_ready=1.
REQ-011 ovf  output  1  sticky flag; a result was dropped.
REQ-012 ovf_clr  input  1  clears ovf.

Function
REQ-013 Decode table (seg_in -> bcd): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 0011111->6, 1110000->7, 1111111->8, 1110011->9.
REQ-014 Pattern 0000000 -> bcd_out=4'hF, blank_out=1, err_out=0; any other pattern not in REQ-013 -> bcd_out=4'hF, blank_out=0, err_out=1; legal digit -> blank_out=0, err_out=0.
REQ-015 Stability filter: internal candidate register cand[6:0] and counter cnt[3:0]; cnt saturates at STABLE_CNT.
REQ-016 Strobe with seg_in==cand and cnt<STABLE_CNT: cnt increments; with seg_in==cand and cnt==STABLE_CNT: no change.
REQ-017 Strobe with seg_in!=cand: cand<=seg_in, cnt<=1.
REQ-018 Qualifying event: a strobe that makes cnt equal STABLE_CNT this cycle. With STABLE_CNT=1, every strobe with seg_in!=cand qualifies.
REQ-019 A qualifying event generates a result only if no pattern has been reported since reset, or seg_in differs from the last reported pattern (last_pat); on generation, last_pat<=seg_in.
REQ-020 Result register is a two-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-021 EMPTY + result -> load, go FULL; out_valid=1 on the cycle after the qualifying strobe (latency 1 clock).
REQ-022 FULL + out_ready=1 + no result -> go EMPTY.
REQ-023 FULL + out_ready=1 + result in the same cycle -> load new result, stay FULL, no drop.
REQ-024 FULL + out_ready=0 + result -> keep old result unchanged, drop new one, set ovf=1; last_pat still updates.
REQ-025 bcd_out/blank_out/err_out are stable while FULL and not accepted.
REQ-026 ovf_clr=1 clears ovf next cycle; a drop in the same cycle as ovf_clr leaves ovf=1 (set wins).
REQ-027 Cycles with seg_stb=0 change neither cand nor cnt.

Reset
REQ-028 rst_n=0 at a clock edge: out_valid=0, bcd_out=0, blank_out=0, err_out=0, ovf=0, cand=0000000, cnt=0, "reported since reset" flag cleared; this holds regardless of state or an in-progress filter count.
REQ-029 First strobe after reset with seg_in=0000000 counts as a match to cand (cnt->1), not a mismatch.

Verification (STABLE_CNT=3 unless stated)
REQ-030 Strobe 1101101 three times, out_ready=1 -> one cycle after third strobe out_valid=1, bcd_out=2, err_out=0; a fourth identical strobe produces no new result.
REQ-031 Strobes 1111001,1111001,0110000,1111001,1111001,1111001 -> exactly one result, bcd_out=3, after the sixth strobe.
REQ-032 Three strobes of 1000000 -> bcd_out=F, err_out=1; three strobes of 0000000 after reset -> bcd_out=F, blank_out=1.
REQ-033 out_ready=0, stable 5 then stable 7 -> out_valid holds bcd_out=5, ovf=1; assert out_ready -> 5 consumed, out_valid=0; pulse ovf_clr -> ovf=0.
REQ-034 FULL with 4 and out_ready=1 in the cycle a stable 9 qualifies -> next cycle bcd_out=9, out_valid=1, ovf=0.
REQ-035 rst_n=0 after two strobes of 0110011, then one strobe of 0110011 -> no result (count restarted); two more strobes -> result bcd_out=4.
